// File: rtl/ac_motor_ramp_control_if.sv
// ac_motor_ramp_control_if
// Command/drive bundle between the speed-command source (master) and the
// ramp controller (slave). CLK and RST stay outside as plain ports.
interface ac_motor_ramp_control_if #(
    parameter int WIDTH = 13
);
    logic                    ENABLE;
    logic signed [WIDTH-1:0] POWER;
    logic                    CW;
    logic                    CCW;
    logic        [WIDTH-1:0] FREQUENCY;
    logic signed [WIDTH-1:0] AMPLITUDE;
    logic                    AT_SPEED;

    modport master (
        output ENABLE, POWER,
        input  CW, CCW, FREQUENCY, AMPLITUDE, AT_SPEED
    );

    modport slave (
        input  ENABLE, POWER,
        output CW, CCW, FREQUENCY, AMPLITUDE, AT_SPEED
    );
endinterface

// File: rtl/ac_motor_ramp_control.sv
// ac_motor_ramp_control
// Turns a signed power command into a slew-limited drive frequency, a V/f
// amplitude and CW/CCW enables. Reversal always goes brake-to-zero, dead
// time, then ramp up in the new direction.
// Optional feature macro: AC_MOTOR_VF_BOOST_EN adds a low-speed amplitude
// offset (BOOST) while a direction is enabled; without it AMPLITUDE tracks
// FREQUENCY one-to-one.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no drive, FREQUENCY=0, waiting for a nonzero target
// ST_DEAD  | both directions off for DEAD_CYCLES before (re)starting
// ST_RUN   | direction latched, FREQUENCY ramps toward target magnitude
// ST_BRAKE | direction held, FREQUENCY ramps to 0 before stop/reverse
module ac_motor_ramp_control #(
    parameter int WIDTH       = 13,
    parameter int RAMP_DIV    = 1024,
    parameter int STEP        = 8,
    parameter int DEAD_CYCLES = 256,
    parameter int BOOST       = 200
) (
    input  logic                       CLK,
    input  logic                       RST,
    ac_motor_ramp_control_if.slave     bus
);

    localparam int PW = $clog2(RAMP_DIV + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    localparam logic [WIDTH-1:0] MAG_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAG_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [PW-1:0]    PRE_LAST  = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEAD_CYCLES - 1);

    // Reject parameter sets that would break the ramp or dead-time timing.
    if (WIDTH < 2 || RAMP_DIV < 1 || STEP < 1 || DEAD_CYCLES < 1 || BOOST < 0) begin : g_param_err
        $error("ac_motor_ramp_control: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_RUN,
        ST_BRAKE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] freq_q,  freq_d;
    logic [WIDTH-1:0] amp_q,   amp_d;
    logic             cw_q,    cw_d;
    logic             ccw_q,   ccw_d;
    logic             at_q,    at_d;
    logic             dir_q,   dir_d;     // 1 = CCW
    logic [PW-1:0]    pre_q,   pre_d;
    logic [DW-1:0]    dead_q,  dead_d;

    logic [WIDTH-1:0] power_u;
    logic [WIDTH-1:0] neg_u;
    logic [WIDTH-1:0] tgt_mag;
    logic             tgt_nz;
    logic             tgt_neg;
    logic             tick;

    // Move cur by at most STEP toward goal, landing exactly on goal.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] goal);
        logic [WIDTH-1:0] res;
        res = goal;
        if (cur < goal) begin
            if ((goal - cur) > STEP_W) res = cur + STEP_W;
        end else if (cur > goal) begin
            if ((cur - goal) > STEP_W) res = cur - STEP_W;
        end
        return res;
    endfunction

    // Target magnitude/direction from the command; most-negative clamps to max.
    always_comb begin
        power_u = bus.POWER;
        neg_u   = (~power_u) + {{(WIDTH-1){1'b0}}, 1'b1};
        tgt_mag = '0;
        if (bus.ENABLE) begin
            if (!power_u[WIDTH-1])      tgt_mag = power_u;
            else if (power_u == MAG_MIN) tgt_mag = MAG_MAX;
            else                         tgt_mag = neg_u;
        end
        tgt_nz  = (tgt_mag != '0);
        tgt_neg = bus.ENABLE & power_u[WIDTH-1];
    end

    // Next-state, ramp, prescaler and dead-time logic.
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        cw_d    = cw_q;
        ccw_d   = ccw_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        tick    = (pre_q == PRE_LAST);
        pre_d   = tick ? '0 : pre_q + PW'(1);

        case (state_q)
            ST_IDLE: begin
                freq_d = '0;
                cw_d   = 1'b0;
                ccw_d  = 1'b0;
                if (tgt_nz) begin
                    state_d = ST_DEAD;
                    dead_d  = DEAD_LOAD;
                end
            end
            ST_DEAD: begin
                cw_d  = 1'b0;
                ccw_d = 1'b0;
                if (!tgt_nz) begin
                    state_d = ST_IDLE;
                    dead_d  = '0;
                end else if (dead_q == '0) begin
                    state_d = ST_RUN;
                    dir_d   = tgt_neg;
                    cw_d    = ~tgt_neg;
                    ccw_d   = tgt_neg;
                end else begin
                    dead_d = dead_q - DW'(1);
                end
            end
            ST_RUN: begin
                if (!tgt_nz || (tgt_neg != dir_q)) begin
                    state_d = ST_BRAKE;
                    if (tick) freq_d = step_toward(freq_q, '0);
                end else if (tick) begin
                    freq_d = step_toward(freq_q, tgt_mag);
                end
            end
            ST_BRAKE: begin
                if (tick) freq_d = step_toward(freq_q, '0);
                if (freq_q == '0) begin
                    if (!tgt_nz) begin
                        state_d = ST_IDLE;
                        cw_d    = 1'b0;
                        ccw_d   = 1'b0;
                    end else if (tgt_neg != dir_q) begin
                        state_d = ST_DEAD;
                        dead_d  = DEAD_LOAD;
                        cw_d    = 1'b0;
                        ccw_d   = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                freq_d  = '0;
                cw_d    = 1'b0;
                ccw_d   = 1'b0;
            end
        endcase

        at_d = (state_d == ST_RUN) && tgt_nz && (freq_d == tgt_mag) && (tgt_neg == dir_d);
    end

`ifdef AC_MOTOR_VF_BOOST_EN
    logic [WIDTH:0] boost_sum;

    // Boosted V/f: offset while driving, saturated at the positive maximum.
    always_comb begin
        boost_sum = {1'b0, freq_d} + (WIDTH+1)'(BOOST);
        amp_d     = '0;
        if (cw_d || ccw_d) begin
            if (boost_sum > {1'b0, MAG_MAX}) amp_d = MAG_MAX;
            else                             amp_d = boost_sum[WIDTH-1:0];
        end
    end
`else
    // Linear V/f: amplitude follows frequency exactly.
    always_comb begin
        amp_d = freq_d;
    end
`endif

    // State and output registers; synchronous reset is an immediate stop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            freq_q  <= '0;
            amp_q   <= '0;
            cw_q    <= 1'b0;
            ccw_q   <= 1'b0;
            at_q    <= 1'b0;
            dir_q   <= 1'b0;
            pre_q   <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            cw_q    <= cw_d;
            ccw_q   <= ccw_d;
            at_q    <= at_d;
            dir_q   <= dir_d;
            pre_q   <= pre_d;
            dead_q  <= dead_d;
        end
    end

    assign bus.CW        = cw_q;
    assign bus.CCW       = ccw_q;
    assign bus.FREQUENCY = freq_q;
    assign bus.AMPLITUDE = amp_q;
    assign bus.AT_SPEED  = at_q;

endmodule

// File: tb/tb_ac_motor_ramp_control.sv
// tb_ac_motor_ramp_control
// Directed test-plan scenarios followed by randomized command segments; every
// cycle the DUT outputs are compared with a behavioural model of the
// controller (phase + signed direction + arithmetic slew toward a goal).
module tb_ac_motor_ramp_control;
    localparam int W    = 13;
    localparam int RD   = 4;
    localparam int ST   = 16;
    localparam int DC   = 8;
    localparam int BST  = 200;
    localparam int MAXM = 4095;

    localparam int PH_IDLE  = 0;
    localparam int PH_DEAD  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_BRAKE = 3;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    ac_motor_ramp_control_if #(.WIDTH(W)) bus ();

    ac_motor_ramp_control #(
        .WIDTH(W), .RAMP_DIV(RD), .STEP(ST), .DEAD_CYCLES(DC), .BOOST(BST)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int m_ph, m_cnt, m_freq, m_dir, m_pre, m_mag, m_sgn;
    int m_cw, m_ccw, m_at, m_amp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int slew(input int cur, input int goal);
        int d;
        d = goal - cur;
        if (d > ST)  d = ST;
        if (d < -ST) d = -ST;
        return cur + d;
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_cnt = 0; m_freq = 0; m_dir = 1; m_pre = 0;
    endtask

    // Advance the model by one rising edge using the inputs present before it.
    task automatic model_edge();
        int p, old_f;
        bit tk;
        if (RST) begin
            model_reset();
        end else begin
            p     = $signed(bus.POWER);
            m_mag = bus.ENABLE ? (p < 0 ? -p : p) : 0;
            if (m_mag > MAXM) m_mag = MAXM;
            m_sgn = (m_mag == 0) ? 0 : (p < 0 ? -1 : 1);
            tk    = (m_pre == RD - 1);
            m_pre = (m_pre + 1) % RD;
            old_f = m_freq;
            case (m_ph)
                PH_IDLE: if (m_mag != 0) begin m_ph = PH_DEAD; m_cnt = 1; end
                PH_DEAD: begin
                    if (m_mag == 0) m_ph = PH_IDLE;
                    else if (m_cnt == DC) begin m_ph = PH_RUN; m_dir = m_sgn; end
                    else m_cnt++;
                end
                PH_RUN: begin
                    if (m_sgn != m_dir) begin
                        m_ph = PH_BRAKE;
                        if (tk) m_freq = slew(m_freq, 0);
                    end else if (tk) m_freq = slew(m_freq, m_mag);
                end
                default: begin
                    if (tk) m_freq = slew(m_freq, 0);
                    if (old_f == 0) begin
                        if (m_sgn == 0) m_ph = PH_IDLE;
                        else if (m_sgn != m_dir) begin m_ph = PH_DEAD; m_cnt = 1; end
                        else m_ph = PH_RUN;
                    end
                end
            endcase
        end
        m_cw  = ((m_ph == PH_RUN || m_ph == PH_BRAKE) && m_dir == 1)  ? 1 : 0;
        m_ccw = ((m_ph == PH_RUN || m_ph == PH_BRAKE) && m_dir == -1) ? 1 : 0;
        m_at  = (!RST && m_ph == PH_RUN && m_sgn == m_dir && m_freq == m_mag) ? 1 : 0;
`ifdef AC_MOTOR_VF_BOOST_EN
        m_amp = (m_cw || m_ccw) ? ((m_freq + BST > MAXM) ? MAXM : m_freq + BST) : 0;
`else
        m_amp = m_freq;
`endif
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
        chk("freq",     32'(bus.FREQUENCY), 32'(m_freq));
        chk("amp",      32'($signed(bus.AMPLITUDE)), 32'(m_amp));
        chk("cw",       32'(bus.CW),        32'(m_cw));
        chk("ccw",      32'(bus.CCW),       32'(m_ccw));
        chk("at_speed", 32'(bus.AT_SPEED),  32'(m_at));
        chk("excl",     32'(bus.CW & bus.CCW), 32'(0));
    endtask

    task automatic wait_out(input string tag, input int f, input int cw, input int ccw, input int lim);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < lim && !hit; i++) begin
            cyc();
            if (bus.FREQUENCY == W'(f) && bus.CW == cw[0] && bus.CCW == ccw[0]) hit = 1'b1;
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s timeout observed_freq=%0d expected_freq=%0d", tag, bus.FREQUENCY, f);
        end
    endtask

    initial begin
        model_reset();
        RST = 1'b1; bus.ENABLE = 1'b1; bus.POWER = 13'sd1000;

        // Reset held with a nonzero command, then dead time before first start.
        repeat (3) cyc();
        chk("rst_freq", 32'(bus.FREQUENCY), 32'(0));
        chk("rst_cw",   32'(bus.CW),        32'(0));
        RST = 1'b0;
        repeat (DC) cyc();
        chk("dead_cw_low", 32'(bus.CW), 32'(0));
        cyc();
        chk("start_cw", 32'(bus.CW), 32'(1));

        // Ramp up to 100 from a fresh reset.
        RST = 1'b1; cyc();
        RST = 1'b0; bus.POWER = 13'sd100;
        wait_out("ramp100", 100, 1, 0, 200);
        chk("ramp_at_speed", 32'(bus.AT_SPEED), 32'(1));
        chk("ramp_amp",      32'(bus.AMPLITUDE), 32'(100));
        repeat (10) cyc();
        chk("ramp_hold", 32'(bus.FREQUENCY), 32'(100));

        // Reversal to -50.
        bus.POWER = -13'sd50;
        wait_out("rev_zero", 0, 0, 0, 200);
        wait_out("rev50", 50, 0, 1, 300);
        chk("rev_ccw", 32'(bus.CCW), 32'(1));

        // Most-negative command clamps to 4095, then ENABLE=0 ramps to idle.
        bus.POWER = 13'sh1000;
        wait_out("sat4095", MAXM, 0, 1, 1500);
        chk("sat_at_speed", 32'(bus.AT_SPEED), 32'(1));
        repeat (8) cyc();
        chk("sat_hold", 32'(bus.FREQUENCY), 32'(MAXM));
        bus.ENABLE = 1'b0;
        wait_out("disable_idle", 0, 0, 0, 1500);
        repeat (4) cyc();
        chk("idle_ccw", 32'(bus.CCW), 32'(0));

        // Emergency reset mid-ramp.
        bus.ENABLE = 1'b1; bus.POWER = 13'sd100;
        wait_out("abort48", 48, 1, 0, 200);
        RST = 1'b1; cyc();
        chk("abort_freq", 32'(bus.FREQUENCY), 32'(0));
        chk("abort_cw",   32'(bus.CW),        32'(0));
        RST = 1'b0;

        // Command flips back to +100 while in dead time of a reversal.
        wait_out("pre_rev100", 100, 1, 0, 300);
        bus.POWER = -13'sd50;
        wait_out("rev_dead", 0, 0, 0, 200);
        repeat (3) cyc();
        bus.POWER = 13'sd100;
        wait_out("back_cw", 100, 1, 0, 300);
        chk("back_ccw", 32'(bus.CCW), 32'(0));

        // Randomized command segments against the model.
        for (int s = 0; s < 40; s++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      bus.POWER = 13'sh1000;
            else if (r == 1) bus.POWER = '0;
            else             bus.POWER = W'(int'($urandom_range(0, 800)) - 400);
            bus.ENABLE = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) begin
                RST = 1'b1; cyc(); RST = 1'b0;
            end
            repeat ($urandom_range(5, 300)) cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ac_motor_ramp_control.md
# ac_motor_ramp_control

Parametrised successor to the fixed-setpoint AC motor controller. Converts a signed power command into a slew-limited drive frequency, a V/f-proportional amplitude and CW/CCW direction enables, with a safe reversal sequence: ramp to zero, dead time, then ramp up in the new direction. Sits between the command interface and the sine/PWM generator that consumes FREQUENCY and AMPLITUDE.

## Interface
- WIDTH, 13: command/output width; magnitude range 0..2^(WIDTH-1)-1.
- RAMP_DIV, 1024: CLK cycles per ramp tick (≥1).
- STEP, 8: frequency change per ramp tick (≥1).
- DEAD_CYCLES, 256: CLK cycles with CW=CCW=0 during reversal (≥1).
- BOOST, 200: low-speed amplitude offset (used only with AC_MOTOR_VF_BOOST_EN).

- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  0 forces target to zero (controlled ramp-down, not a cut).
- POWER  in  WIDTH signed  speed command; sign = direction (positive = CW).
- CW  out  1  clockwise enable (registered).
- CCW  out  1  counter-clockwise enable (registered).
- FREQUENCY  out  WIDTH unsigned  current drive frequency magnitude.
- AMPLITUDE  out  WIDTH signed  drive amplitude, always ≥0.
- AT_SPEED  out  1  FREQUENCY equals target magnitude in RUN.

## Operation
- Target: |POWER| when ENABLE=1, else 0; POWER = -2^(WIDTH-1) clamps to magnitude 2^(WIDTH-1)-1. Target direction = sign of POWER; zero has no direction.
- Prescaler counts 0..RAMP_DIV-1; tick asserted on the wrap cycle; free-running from reset.
- States:
  - IDLE: CW=CCW=0, FREQUENCY=0. Nonzero target → DEAD (DEAD_CYCLES also precede the first start).
  - DEAD: CW=CCW=0, counter runs DEAD_CYCLES; on expiry latch target direction, → RUN. If target becomes 0 during DEAD → IDLE.
  - RUN: direction output held; on each tick FREQUENCY moves STEP toward target magnitude, saturating exactly at target (no overshoot). Target direction differs from latched direction, or target 0 → BRAKE.
  - BRAKE: direction held; on each tick FREQUENCY decreases by STEP, floored at 0. At 0: target 0 → IDLE; opposite direction → DEAD; same direction again → RUN.
  - Direction reversal never changes CW/CCW while FREQUENCY>0; CW and CCW are never both 1.
- AMPLITUDE = FREQUENCY (linear V/f), registered alongside FREQUENCY.
- AT_SPEED = 1 only in RUN with FREQUENCY == target magnitude and target nonzero.
- Target changes in RUN with same direction simply retarget; a lower target ramps down without BRAKE.

## Timing
- Reset values: CW=0, CCW=0, FREQUENCY=0, AMPLITUDE=0, AT_SPEED=0, state IDLE, prescaler 0, dead counter 0.
- RST mid-ramp/mid-dead takes effect at the next edge; outputs return to reset values immediately (emergency stop; no ramp).
- POWER/ENABLE sampled every cycle; state transition decided on the cycle the condition holds, effective next edge.
- FREQUENCY/AMPLITUDE update one cycle after tick; AT_SPEED in the same cycle as the matching FREQUENCY.
- DEAD duration exactly DEAD_CYCLES cycles with CW=CCW=0 from entry edge to direction assertion.
- Ramp time from 0 to magnitude M: ceil(M/STEP) ticks.

## Configuration
- AC_MOTOR_VF_BOOST_EN defined: AMPLITUDE = min(FREQUENCY + BOOST, 2^(WIDTH-1)-1) while CW or CCW is 1; 0 otherwise (IDLE/DEAD).
- Not defined: AMPLITUDE = FREQUENCY; BOOST parameter unused.

## Test plan
- Reset: RST=1 for 3 cycles with POWER=1000 → all outputs 0, state IDLE; after release, DEAD for 8 cycles (DEAD_CYCLES=8), then CW=1.
- Ramp up (RAMP_DIV=4, STEP=16): POWER=100 → FREQUENCY 16,32,…,96,100 every 4 cycles, AT_SPEED=1 at 100, no overshoot.
- Reversal: at FREQUENCY=100 set POWER=-50 → ramp to 0 with CW=1, 8 cycles CW=CCW=0, then CCW=1 and ramp to 50; never CW=CCW=1.
- Extremes: POWER=-4096 → target 4095, CCW=1, FREQUENCY saturates at 4095; ENABLE=0 → ramp to 0 then IDLE.
- Abort: RST asserted mid-ramp at FREQUENCY=48 → next cycle all outputs 0; POWER toggled back to +100 during DEAD from reversal → returns via DEAD to CW.
- Boost (AC_MOTOR_VF_BOOST_EN, BOOST=200): FREQUENCY=16 → AMPLITUDE=216; FREQUENCY=4000 → AMPLITUDE=4095; IDLE → AMPLITUDE=0.
